// File: rtl/armleocpu_regfile_pkg.sv
// Shared types, constants and helpers for the multi-port integer register file.
package armleocpu_regfile_pkg;

  typedef enum logic {
    REGFILE_CLEAR = 1'b0,
    REGFILE_READY = 1'b1
  } regfile_state_t;

  localparam int REGFILE_ZERO_ADDR = 0;

  // An address is writable/readable only if it is not the hardwired zero
  // register and it lies inside a (possibly non-power-of-two) array.
  function automatic logic addr_valid(input logic [31:0] addr, input logic [31:0] count);
    return (addr != 32'(REGFILE_ZERO_ADDR)) && (addr < count);
  endfunction

endpackage

// File: rtl/armleocpu_regfile_clear_ctrl.sv
// Clear sequencer: walks entries 1..REG_COUNT-1 after reset or on request.
module armleocpu_regfile_clear_ctrl #(
  parameter int REG_COUNT = 32,
  parameter int AW        = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          ready,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr
);
  import armleocpu_regfile_pkg::*;

  localparam logic [0:0]    S_CLEAR  = 1'(REGFILE_CLEAR);
  localparam logic [0:0]    S_READY  = 1'(REGFILE_READY);
  localparam logic [AW-1:0] LAST_IDX = AW'(REG_COUNT - 1);

  logic [0:0]    state;
  logic [AW-1:0] clr_idx;

  // Entry 0 is never stored, so the walk starts at 1; requests during a
  // clear are ignored rather than restarting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_idx <= AW'(1);
    end else if (state == S_CLEAR) begin
      clr_idx <= clr_idx + AW'(1);
      if (clr_idx == LAST_IDX) begin
        state <= S_READY;
      end
    end else if (clear_req) begin
      state   <= S_CLEAR;
      clr_idx <= AW'(1);
    end
  end

  assign ready    = (state == S_READY);
  assign clr_en   = (state == S_CLEAR);
  assign clr_addr = clr_idx;

endmodule

// File: rtl/armleocpu_regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass.
module armleocpu_regfile_mp
  import armleocpu_regfile_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_COUNT   = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1,
  parameter int BYPASS      = 1,
  localparam int AW         = $clog2(REG_COUNT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [READ_PORTS*AW-1:0]   rs_addr,
  output logic [READ_PORTS*XLEN-1:0] rs_rdata,
  input  logic [WRITE_PORTS-1:0]     rd_write,
  input  logic [WRITE_PORTS*AW-1:0]  rd_addr,
  input  logic [WRITE_PORTS*XLEN-1:0] rd_wdata,
  input  logic                       clear_req,
  output logic                       ready
);

  logic            clr_en;
  logic [AW-1:0]   clr_addr;
  logic [XLEN-1:0] regs [REG_COUNT];
  logic [AW-1:0]   ra;
  logic [XLEN-1:0] val;

  armleocpu_regfile_clear_ctrl #(
    .REG_COUNT(REG_COUNT),
    .AW       (AW)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clear_req(clear_req),
    .ready    (ready),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  // Ascending port order makes the highest-index writer win a collision.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      regs[clr_addr] <= '0;
    end else if (ready && !rst) begin
      for (int j = 0; j < WRITE_PORTS; j++) begin
        if (rd_write[j] && addr_valid(32'(rd_addr[j*AW +: AW]), 32'(REG_COUNT))) begin
          regs[rd_addr[j*AW +: AW]] <= rd_wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Reads are forced to zero while clearing so stale or uninitialised
  // entries never leak out.
  always_comb begin
    rs_rdata = '0;
    ra       = '0;
    val      = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      ra  = rs_addr[i*AW +: AW];
      val = '0;
      if (ready && addr_valid(32'(ra), 32'(REG_COUNT))) begin
        val = regs[ra];
        if (BYPASS != 0) begin
          for (int j = 0; j < WRITE_PORTS; j++) begin
            if (rd_write[j] && (rd_addr[j*AW +: AW] == ra)) begin
              val = rd_wdata[j*XLEN +: XLEN];
            end
          end
        end
      end
      rs_rdata[i*XLEN +: XLEN] = val;
    end
  end

endmodule
